acc_arbiter: RTL and testbench
==============================

ACC_ARBITER -- requirements
Module: acc_arbiter

Interface
REQ-001 Parameter LENGTH, default 10, SHALL set the accumulator and result width in bits.
REQ-002 Parameter BURST, default 8, range 1..255, SHALL set the number of samples accumulated per grant.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid  input  4  SHALL flag, per requester i, a valid sample on req_data[5i+4:5i].
REQ-006 req_data  input  20  SHALL carry four 5-bit unsigned samples, requester i at bits [5i+4:5i].
REQ-007 req_ready  output  4  SHALL accept a sample from requester i on a cycle with req_valid[i] and req_ready[i] both high.
REQ-008 res_valid  output  1  SHALL flag that res_id and res_sum hold a finished result.
REQ-009 res_id  output  2  SHALL identify the requester owning the result.
REQ-010 res_sum  output  LENGTH  SHALL carry the accumulated burst total.
REQ-011 res_ready  input  1  SHALL let the consumer take the result on a cycle with res_valid and res_ready both high.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-014 IDLE, any req_valid high: SHALL pick a grant round-robin, starting the search at pointer ptr and wrapping 3->0.
  - Grant goes to the first i with req_valid[i]=1.
  - Next cycle: ACCUM, sum cleared to 0, sample count cleared to 0.
REQ-015 IDLE, no req_valid: SHALL stay in IDLE with all req_ready low.
REQ-016 In ACCUM, req_ready SHALL be one-hot on the granted requester and all other bits SHALL be 0.
REQ-017 Each accepted sample SHALL do two things:
  - sum <= (sum + zero-extended sample) mod 2^LENGTH; overflow wraps silently.
  - count increments by 1.
REQ-018 Accepting the BURST-th sample SHALL move the FSM to DONE on the next cycle.
  - req_ready drops to 0 in that same next cycle.
  - The BURST-th sample is included in the sum.
REQ-019 Granted requester deasserting req_valid mid-burst: SHALL stay in ACCUM, holding sum and count, with no timeout and no change of grant.
REQ-020 In DONE, SHALL drive res_valid=1, res_id=grant and res_sum=sum, all stable until the res_valid/res_ready handshake.
REQ-021 On the handshake cycle, SHALL set ptr <= grant+1 (mod 4) and move to IDLE on the next cycle.
  - res_ready already high on DONE entry: DONE lasts exactly one cycle.
REQ-022 Outside DONE, res_valid SHALL be 0, and res_id and res_sum SHALL hold their last values.
REQ-023 Minimum burst latency SHALL be BURST+2 cycles, from req_valid seen in IDLE to res_valid high, with req_valid continuously high.
REQ-024 Requests from non-granted requesters SHALL be ignored (never accepted) until the FSM returns to IDLE.

Reset
REQ-025 resetn low SHALL immediately force all of the following, regardless of state:
  - state = IDLE, ptr = 0, grant = 0, sum = 0, count = 0.
  - req_ready = 0, res_valid = 0, res_id = 0, res_sum = 0, busy = 0.
  - Any in-progress burst or pending result is discarded.
REQ-026 After resetn deasserts, the first grant SHALL go to the lowest-index requester with req_valid high.

Verification
REQ-027 BURST=8; only requester 2 valid; samples 1..8; res_ready=1. Required: res_valid for 1 cycle with res_id=2 and res_sum=36; res_valid exactly 10 cycles after the first valid.
REQ-028 All four valid continuously; 5 bursts. Required: grant order 0,1,2,3,0; req_ready always one-hot or zero.
REQ-029 LENGTH=6, BURST=8, samples all 31. Required: res_sum = 248 mod 64 = 56.
REQ-030 Requester 1 drops valid for 5 cycles after sample 3. Required: state stays ACCUM, no other requester accepted, final sum correct.
REQ-031 res_ready held low for 6 cycles in DONE. Required: res_valid, res_id and res_sum stable throughout; no req_ready asserted.
REQ-032 resetn pulsed low mid-ACCUM after 4 samples. Required: all outputs 0 asynchronously; next burst starts from sum 0 at requester 0 priority.

Source files
------------

// File: rtl/acc_arbiter_if.sv
// Request/result bundle of the burst-accumulating arbiter: four 5-bit sample
// sources in, one tagged burst total out.
interface acc_arbiter_if #(
   parameter int LENGTH = 10
);
   logic [3:0]        req_valid;
   logic [19:0]       req_data;
   logic [3:0]        req_ready;
   logic              res_valid;
   logic [1:0]        res_id;
   logic [LENGTH-1:0] res_sum;
   logic              res_ready;
   logic              busy;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, res_valid, res_id, res_sum, busy
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, res_valid, res_id, res_sum, busy
   );
endinterface

// File: rtl/acc_arbiter.sv
// Round-robin arbiter that grants one of four requesters, sums BURST of its
// samples, and presents the total with the owner's id until it is taken.
module acc_arbiter #(
   parameter int LENGTH = 10,
   parameter int BURST  = 8
) (
   input  logic         clk,
   input  logic         resetn,
   acc_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_COUNT = 8'(BURST - 1);

   state_t            state_r, state_s;
   logic [1:0]        ptr_r, ptr_s;
   logic [1:0]        grant_r, grant_s;
   logic [1:0]        pick_s, idx_s;
   logic              found_s;
   logic [LENGTH-1:0] sum_r, sum_s;
   logic [7:0]        count_r, count_s;
   logic [3:0]        ready_r, ready_s;
   logic              res_valid_r, res_valid_s;
   logic [1:0]        res_id_r, res_id_s;
   logic [LENGTH-1:0] res_sum_r, res_sum_s;
   logic              busy_r;
   logic [4:0]        sample_s;
   logic              accept_s;

   // First valid requester at or after ptr, wrapping 3 -> 0.
   always_comb begin
      pick_s  = ptr_r;
      found_s = 1'b0;
      idx_s   = ptr_r;
      for (int k = 0; k < 4; k++) begin
         idx_s = ptr_r + 2'(k);
         if (!found_s && bus.req_valid[idx_s]) begin
            pick_s  = idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Sample lane of the granted requester and its handshake.
   always_comb begin
      sample_s = 5'd0;
      case (grant_r)
         2'd0:    sample_s = bus.req_data[4:0];
         2'd1:    sample_s = bus.req_data[9:5];
         2'd2:    sample_s = bus.req_data[14:10];
         2'd3:    sample_s = bus.req_data[19:15];
         default: sample_s = 5'd0;
      endcase
      accept_s = (state_r == ACCUM) && ready_r[grant_r] && bus.req_valid[grant_r];
   end

   // Next-state and next-output logic; outputs are registered from these values.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      grant_s     = grant_r;
      sum_s       = sum_r;
      count_s     = count_r;
      ready_s     = 4'b0000;
      res_valid_s = 1'b0;
      res_id_s    = res_id_r;
      res_sum_s   = res_sum_r;
      case (state_r)
         IDLE: begin
            if (|bus.req_valid) begin
               grant_s = pick_s;
               sum_s   = '0;
               count_s = 8'd0;
               state_s = ACCUM;
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            // ready opens one cycle after entry, which yields the BURST+2 latency
            ready_s = 4'b0001 << grant_r;
            if (accept_s) begin
               sum_s   = sum_r + {{(LENGTH-5){1'b0}}, sample_s};
               count_s = count_r + 8'd1;
               if (count_r == LAST_COUNT) begin
                  state_s     = DONE;
                  ready_s     = 4'b0000;
                  res_valid_s = 1'b1;
                  res_id_s    = grant_r;
                  res_sum_s   = sum_s;
               end else begin
                  state_s = ACCUM;
               end
            end else begin
               state_s = ACCUM;
            end
         end
         DONE: begin
            res_valid_s = 1'b1;
            if (bus.res_ready) begin
               ptr_s       = grant_r + 2'd1;
               state_s     = IDLE;
               res_valid_s = 1'b0;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= IDLE;
         ptr_r       <= 2'd0;
         grant_r     <= 2'd0;
         sum_r       <= '0;
         count_r     <= 8'd0;
         ready_r     <= 4'b0000;
         res_valid_r <= 1'b0;
         res_id_r    <= 2'd0;
         res_sum_r   <= '0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         grant_r     <= grant_s;
         sum_r       <= sum_s;
         count_r     <= count_s;
         ready_r     <= ready_s;
         res_valid_r <= res_valid_s;
         res_id_r    <= res_id_s;
         res_sum_r   <= res_sum_s;
         busy_r      <= (state_s != IDLE);
      end
   end

   assign bus.req_ready = ready_r;
   assign bus.res_valid = res_valid_r;
   assign bus.res_id    = res_id_r;
   assign bus.res_sum   = res_sum_r;
   assign bus.busy      = busy_r;
endmodule

// File: tb/tb_acc_arbiter.sv
// Bench for acc_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of grant order, burst sums and latency.
module tb_acc_arbiter;
   localparam int LENGTH = 10;
   localparam int BURST  = 8;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   acc_arbiter_if #(.LENGTH(LENGTH)) bus ();
   acc_arbiter_if #(.LENGTH(6))      bus6 ();

   acc_arbiter #(.LENGTH(LENGTH), .BURST(BURST)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   acc_arbiter #(.LENGTH(6), .BURST(8)) dut6 (.clk(clk), .resetn(resetn), .bus(bus6));

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] drv_valid;
   logic       drv_res_ready;
   logic [4:0] src [4];
   int         gen_mode;

   // reference model: phase 0 idle, 1 accumulating, 2 result pending
   int m_phase, m_ptr, m_grant, m_count, m_sum, m_last_id, m_last_sum;
   bit m_first;
   int cycle_no, t_valid, t_res, rv_cycles;
   int res_log[$];
   int dut_ids[$];

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int ptr);
      for (int k = 0; k < 4; k++) begin
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return ptr;
   endfunction

   function automatic logic [4:0] next_sample(input logic [4:0] cur);
      if (gen_mode == 1) return cur + 5'd1;
      if (gen_mode == 2) return 5'd31;
      return 5'($urandom_range(0, 31));
   endfunction

   task automatic model_clear();
      m_phase = 0; m_ptr = 0; m_grant = 0; m_count = 0; m_sum = 0;
      m_last_id = 0; m_last_sum = 0; m_first = 1'b0;
   endtask

   task automatic run_cycle();
      logic [3:0] accepted;
      logic [3:0] exp_ready;
      @(posedge clk);
      #1;
      bus.req_valid = drv_valid;
      bus.req_data  = {src[3], src[2], src[1], src[0]};
      bus.res_ready = drv_res_ready;
      #1;
      exp_ready = (m_phase == 1 && !m_first) ? (4'b0001 << m_grant) : 4'b0000;
      check_value("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check_value("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
      check_value("busy", 32'(bus.busy), 32'(m_phase != 0));
      check_value("res_valid", 32'(bus.res_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
         check_value("res_id", 32'(bus.res_id), 32'(m_grant));
         check_value("res_sum", 32'(bus.res_sum), 32'(m_sum));
      end else begin
         check_value("res_id_hold", 32'(bus.res_id), 32'(m_last_id));
         check_value("res_sum_hold", 32'(bus.res_sum), 32'(m_last_sum));
      end
      if (bus.res_valid) begin
         rv_cycles++;
         if (t_res < 0) t_res = cycle_no;
         if (drv_res_ready) dut_ids.push_back(int'(bus.res_id));
      end
      accepted = bus.req_ready & drv_valid;
      case (m_phase)
         0: begin
            if (drv_valid != 4'b0000) begin
               m_grant = rr_pick(drv_valid, m_ptr);
               m_phase = 1; m_first = 1'b1; m_count = 0; m_sum = 0;
               if (t_valid < 0) t_valid = cycle_no;
            end
         end
         1: begin
            m_first = 1'b0;
            if (accepted[m_grant]) begin
               m_sum = (m_sum + int'(src[m_grant])) % (1 << LENGTH);
               m_count++;
               if (m_count == BURST) m_phase = 2;
            end
         end
         default: begin
            if (drv_res_ready) begin
               m_last_id = m_grant; m_last_sum = m_sum;
               m_ptr = (m_grant + 1) % 4; m_phase = 0;
               res_log.push_back(m_grant);
            end
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         if (accepted[i]) src[i] = next_sample(src[i]);
      end
      cycle_no++;
   endtask

   task automatic run_until(input int n, input int budget);
      int start = res_log.size();
      int c = 0;
      while (res_log.size() < start + n && c < budget) begin
         run_cycle();
         c++;
      end
      check_value("result_timeout", 32'(res_log.size() >= start + n), 32'd1);
   endtask

   task automatic run_until_count(input int cnt, input int budget);
      int c = 0;
      while (!(m_phase == 1 && m_count == cnt) && c < budget) begin
         run_cycle();
         c++;
      end
      check_value("count_timeout", 32'(m_phase == 1 && m_count == cnt), 32'd1);
   endtask

   task automatic do_reset();
      #1;
      resetn = 1'b0;
      drv_valid = 4'b0000;
      bus.req_valid = 4'b0000;
      bus6.req_valid = 4'b0000;
      #1;
      check_value("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check_value("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check_value("rst_res_id", 32'(bus.res_id), 32'd0);
      check_value("rst_res_sum", 32'(bus.res_sum), 32'd0);
      check_value("rst_busy", 32'(bus.busy), 32'd0);
      model_clear();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   int exp_order [5] = '{0, 1, 2, 3, 0};

   initial begin
      int c;
      drv_valid = 4'b0000; drv_res_ready = 1'b1; gen_mode = 0;
      for (int i = 0; i < 4; i++) src[i] = 5'd0;
      bus.req_valid = 4'b0000; bus.req_data = 20'd0; bus.res_ready = 1'b1;
      bus6.req_valid = 4'b0000; bus6.req_data = 20'd0; bus6.res_ready = 1'b1;
      cycle_no = 0; t_valid = -1; t_res = -1; rv_cycles = 0;
      model_clear();
      do_reset();

      // narrow accumulator wraps: 8 x 31 = 248 -> 56 mod 64
      bus6.req_data = 20'hFFFFF;
      bus6.req_valid = 4'b0001;
      c = 0;
      while (!bus6.res_valid && c < 40) begin
         @(posedge clk);
         #2;
         c++;
      end
      check_value("wrap_valid", 32'(bus6.res_valid), 32'd1);
      check_value("wrap_sum", 32'(bus6.res_sum), 32'd56);
      check_value("wrap_id", 32'(bus6.res_id), 32'd0);
      bus6.req_valid = 4'b0000;

      // only requester 2, samples 1..8
      gen_mode = 1; src[2] = 5'd1; drv_valid = 4'b0100; drv_res_ready = 1'b1;
      t_valid = -1; t_res = -1; rv_cycles = 0;
      run_until(1, 40);
      check_value("latency", 32'(t_res - t_valid), 32'd10);
      check_value("single_res_cycle", 32'(rv_cycles), 32'd1);
      check_value("single_sum", 32'(bus.res_sum), 32'd36);
      check_value("single_id", 32'(bus.res_id), 32'd2);

      // all four valid: grant order 0,1,2,3,0
      do_reset();
      gen_mode = 0; drv_valid = 4'b1111; dut_ids.delete();
      run_until(5, 120);
      check_value("order_len", 32'(dut_ids.size()), 32'd5);
      for (int k = 0; k < 5 && k < dut_ids.size(); k++)
         check_value("grant_order", 32'(dut_ids[k]), 32'(exp_order[k]));

      // requester 1 stalls for 5 cycles after sample 3 while others request
      drv_valid = 4'b0000;
      run_cycle();
      drv_valid = 4'b0010;
      run_until_count(3, 40);
      drv_valid = 4'b1101;
      repeat (5) run_cycle();
      check_value("stall_busy", 32'(bus.busy), 32'd1);
      drv_valid = 4'b1111;
      dut_ids.delete();
      run_until(1, 40);
      check_value("stall_owner", 32'(dut_ids.size() > 0 ? dut_ids[0] : -1), 32'd1);

      // result held while consumer stalls
      drv_res_ready = 1'b0; drv_valid = 4'b1000;
      c = 0;
      while (m_phase != 2 && c < 40) begin
         run_cycle();
         c++;
      end
      repeat (6) begin
         run_cycle();
         check_value("held_valid", 32'(bus.res_valid), 32'd1);
      end
      drv_res_ready = 1'b1;
      run_until(1, 10);

      // reset in the middle of a burst
      drv_valid = 4'b0100;
      run_until_count(4, 40);
      drv_valid = 4'b0000;
      run_cycle();
      do_reset();
      drv_valid = 4'b1111; dut_ids.delete();
      run_until(1, 40);
      check_value("post_rst_id", 32'(dut_ids.size() > 0 ? dut_ids[0] : -1), 32'd0);

      // random traffic with a reset in the middle
      gen_mode = 0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 4; i++) drv_valid[i] = ($urandom_range(0, 9) < 6);
         drv_res_ready = ($urandom_range(0, 3) != 0);
         run_cycle();
         if (n == 300) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
